// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: horizontal segment lengths, pixel prescale
// and the line phase type used by the sync generators.
package vga_timing_pkg;

    localparam int H_SYNC_DFLT  = 192;
    localparam int H_BP_DFLT    = 96;
    localparam int H_DISP_DFLT  = 1280;
    localparam int H_FP_DFLT    = 32;
    localparam int PIX_DIV_DFLT = 10;
    localparam int H_LINE_DFLT  = H_SYNC_DFLT + H_BP_DFLT + H_DISP_DFLT + H_FP_DFLT;

    localparam int HCNT_W    = 11;
    localparam int PIX_CNT_W = 4;
    localparam int HPIX_W    = 7;

    typedef enum logic [1:0] {
        SYNC,
        BACK_PORCH,
        DISPLAY,
        FRONT_PORCH
    } hphase_e;

endpackage

// File: rtl/vga_pixel_div.sv
// Modulo-DIV prescaler with enable and synchronous clear; wrap is high in the
// cycle whose enabled advance returns the count to zero.
module vga_pixel_div #(
    parameter int DIV   = 10,
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_last;

    always_comb begin
        at_last = (cnt_q == CNT_W'(DIV - 1));
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign wrap = en && !clr && at_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_hsync.sv
// Horizontal timing for a 640x480@60 line at 50 MHz: registered active-low
// sync and the 128-column logical pixel index.
module vga_hsync
    import vga_timing_pkg::*;
#(
    parameter int H_SYNC  = H_SYNC_DFLT,
    parameter int H_BP    = H_BP_DFLT,
    parameter int H_DISP  = H_DISP_DFLT,
    parameter int H_FP    = H_FP_DFLT,
    parameter int PIX_DIV = PIX_DIV_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    output logic [HPIX_W-1:0] HPIXEL,
    output logic              VGA_HSYNC
);

    localparam int H_LINE     = H_SYNC + H_BP + H_DISP + H_FP;
    localparam int DISP_START = H_SYNC + H_BP;
    localparam int FP_START   = DISP_START + H_DISP;

    logic [HCNT_W-1:0] hcount_q;
    logic [HCNT_W-1:0] hcount_d;
    hphase_e           state_q;
    hphase_e           state_d;
    logic              hsync_q;
    logic              hsync_d;
    logic [HPIX_W-1:0] hpixel_q;
    logic [HPIX_W-1:0] hpixel_d;
    logic              pix_en;
    logic              pix_clr;
    logic              pix_wrap;

    always_comb begin
        hcount_d = (hcount_q == HCNT_W'(H_LINE - 1)) ? '0 : hcount_q + HCNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // Phase follows the next count so the registered outputs line up with hcount_q.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC:        if (hcount_d == HCNT_W'(H_SYNC))     state_d = BACK_PORCH;
            BACK_PORCH:  if (hcount_d == HCNT_W'(DISP_START)) state_d = DISPLAY;
            DISPLAY:     if (hcount_d == HCNT_W'(FP_START))   state_d = FRONT_PORCH;
            FRONT_PORCH: if (hcount_d == '0)                  state_d = SYNC;
            default:                                          state_d = SYNC;
        endcase
    end

    // Prescaler is held at zero until the first display clock, then steps with it.
    assign pix_en  = (state_q == DISPLAY);
    assign pix_clr = (state_d != DISPLAY);

    vga_pixel_div #(
        .DIV   (PIX_DIV),
        .CNT_W (PIX_CNT_W)
    ) u_pixel_div (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en),
        .clr   (pix_clr),
        .wrap  (pix_wrap)
    );

    always_comb begin
        hsync_d  = (state_d != SYNC);
        hpixel_d = '0;
        if (state_d == DISPLAY) begin
            hpixel_d = pix_wrap ? hpixel_q + HPIX_W'(1) : hpixel_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hsync_q  <= 1'b0;
            hpixel_q <= '0;
        end else begin
            hsync_q  <= hsync_d;
            hpixel_q <= hpixel_d;
        end
    end

    assign VGA_HSYNC = hsync_q;
    assign HPIXEL    = hpixel_q;

endmodule

// File: tb/tb_vga_hsync.sv
// Bench for vga_hsync: per-cycle comparison against an arithmetic line model,
// plus pulse-length, period and pixel-coverage checks around random resets.
module tb_vga_hsync;

    localparam int LINE = 1600;

    logic       clk;
    logic       reset;
    logic [6:0] hpixel;
    logic       hsync;

    vga_hsync dut (
        .clk       (clk),
        .reset     (reset),
        .HPIXEL    (hpixel),
        .VGA_HSYNC (hsync)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ref_h = 0;
    bit in_reset = 1'b1;
    int cyc = 0;
    int low_len, high_len, last_fall;
    bit high_valid, prev_hs, seen_valid;
    bit seen [128];

    function automatic int exp_hsync(int h);
        return (h >= 192) ? 1 : 0;
    endfunction

    function automatic int exp_hpixel(int h);
        return (h >= 288 && h < 1568) ? (h - 288) / 10 : 0;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (hcount %0d)", tag, obs, exp, ref_h);
        end
    endtask

    task automatic restart_stats();
        low_len    = 1;
        high_len   = 0;
        high_valid = 1'b0;
        last_fall  = cyc;
        prev_hs    = 1'b0;
        for (int i = 0; i < 128; i++) seen[i] = 1'b0;
        seen_valid = 1'b1;
    endtask

    task automatic update_stats();
        bit hs;
        int n;
        hs = hsync;
        if (hs && !prev_hs) begin
            check("low_len", low_len, 192);
            high_len   = 1;
            high_valid = 1'b1;
        end else if (!hs && prev_hs) begin
            if (high_valid) check("high_len", high_len, 1408);
            check("period", cyc - last_fall, LINE);
            last_fall = cyc;
            low_len   = 1;
        end else if (hs) begin
            high_len++;
        end else begin
            low_len++;
        end
        prev_hs = hs;

        if (ref_h == 0) begin
            for (int i = 0; i < 128; i++) seen[i] = 1'b0;
            seen_valid = 1'b1;
        end
        if (ref_h >= 288 && ref_h < 1568 && !$isunknown(hpixel)) seen[hpixel] = 1'b1;
        if (ref_h == 1568 && seen_valid) begin
            n = 0;
            for (int i = 0; i < 128; i++) n += seen[i] ? 1 : 0;
            check("distinct", n, 128);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (in_reset) ref_h = 0;
        else ref_h = (ref_h + 1) % LINE;
        #1;
        check("hsync", 32'(hsync), 32'(exp_hsync(ref_h)));
        check("hpixel", 32'(hpixel), 32'(exp_hpixel(ref_h)));
        if (!in_reset) update_stats();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(int target);
        int n;
        n = 0;
        while (ref_h != target && n < LINE + 10) begin
            tick();
            n++;
        end
    endtask

    // Called just after a sampling point; both delays stay inside one clock period.
    task automatic async_reset(int dly_in, int hold, int dly_out);
        #(dly_in);
        reset    = 1'b0;
        in_reset = 1'b1;
        ref_h    = 0;
        #1;
        check("async_hsync", 32'(hsync), 0);
        check("async_hpixel", 32'(hpixel), 0);
        run(hold);
        #(dly_out);
        reset    = 1'b1;
        in_reset = 1'b0;
        restart_stats();
        #1;
        check("release_hsync", 32'(hsync), 0);
        check("release_hpixel", 32'(hpixel), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held across several clock edges
        reset    = 1'b1;
        #2;
        reset    = 1'b0;
        in_reset = 1'b1;
        #1;
        check("rst_hsync", 32'(hsync), 0);
        check("rst_hpixel", 32'(hpixel), 0);
        run(5);

        // Release between edges, then three full lines and a bit
        #5;
        reset    = 1'b1;
        in_reset = 1'b0;
        restart_stats();
        run(3 * LINE + 10);

        // Line wrap
        run_to(1599);
        check("pre_wrap_hsync", 32'(hsync), 1);
        tick();
        check("wrap_hsync", 32'(hsync), 0);
        check("wrap_hpixel", 32'(hpixel), 0);

        // Mid-display abort at hcount 800
        run_to(800);
        check("hpix_800", 32'(hpixel), 51);
        async_reset(5, 2, 7);
        run(LINE + 100);

        // Random abort points, hold lengths and release phases
        for (int k = 0; k < 4; k++) begin
            run_to(int'($urandom_range(0, LINE - 1)));
            async_reset(int'($urandom_range(2, 15)), int'($urandom_range(1, 4)),
                        int'($urandom_range(2, 15)));
            run(int'($urandom_range(LINE, LINE + 400)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
